// File: rtl/bin_morph_nxn.sv
// Binary morphology filter: KSIZE x KSIZE erosion (AND) or dilation (OR) over a
// 1-bit video stream, with the window built from internal line buffers.
module bin_morph_nxn #(
    parameter int IMG_WIDTH = 1280,
    parameter int KSIZE     = 3,
    parameter int CNT_W     = 12
) (
    input  logic video_clk,
    input  logic rst_n,
    input  logic mode,
    input  logic bin_vs,
    input  logic bin_de,
    input  logic bin_data,
    output logic morph_vs,
    output logic morph_de,
    output logic morph_data
);

    localparam int AW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int NLB = KSIZE - 1;

    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
        $error("bin_morph_nxn: KSIZE must be 3 or 5");
    end
    if ((1 << CNT_W) <= IMG_WIDTH) begin : g_bad_cnt_w
        $error("bin_morph_nxn: CNT_W too small for IMG_WIDTH");
    end

    logic             r_vs_d1;
    logic             r_de_d1;
    logic             r_mode;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col_d1;
    logic             r_inrng_d1;
    logic             r_col_red;
    logic [NLB-1:0]   r_hist;

    logic             w_vs_rise;
    logic             w_de_fall;
    logic             w_inrng;
    logic             w_wr;
    logic             w_pad;
    logic [AW-1:0]    w_addr;
    logic [NLB-1:0]   w_rd;
    logic [KSIZE-1:0] w_v;
    logic [KSIZE-1:0] w_hv;
    logic             w_col_red;
    logic             w_win_red;

    assign w_vs_rise = bin_vs & ~r_vs_d1;
    assign w_de_fall = r_de_d1 & ~bin_de;
    assign w_inrng   = (r_col < CNT_W'(IMG_WIDTH));
    assign w_wr      = bin_de & w_inrng;
    assign w_addr    = w_inrng ? r_col[AW-1:0] : '0;
    // Pad value is the neutral element of the active reduction.
    assign w_pad     = ~r_mode;

    // Line buffer g holds row r-1-g; each write pushes the column one row deeper.
    for (genvar g = 0; g < NLB; g++) begin : g_lb
        logic r_mem [IMG_WIDTH];
        logic w_wdata;

        if (g == 0) begin : g_first
            assign w_wdata = bin_data;
        end else begin : g_chain
            assign w_wdata = w_rd[g-1];
        end

        always_ff @(posedge video_clk) begin
            if (w_wr) begin
                r_mem[w_addr] <= w_wdata;
            end
        end

        assign w_rd[g] = r_mem[w_addr];
    end

    assign w_v[0] = bin_data;
    for (genvar g = 1; g < KSIZE; g++) begin : g_vpad
        assign w_v[g] = (r_row < CNT_W'(g)) ? w_pad : w_rd[g-1];
    end

    assign w_hv[0] = r_col_red;
    for (genvar g = 1; g < KSIZE; g++) begin : g_hpad
        assign w_hv[g] = (r_col_d1 < CNT_W'(g)) ? w_pad : r_hist[g-1];
    end

    assign w_col_red = r_mode ? |w_v  : &w_v;
    assign w_win_red = r_mode ? |w_hv : &w_hv;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d1    <= 1'b0;
            r_de_d1    <= 1'b0;
            r_mode     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_col_d1   <= '0;
            r_inrng_d1 <= 1'b0;
            r_col_red  <= 1'b0;
            r_hist     <= '0;
            morph_vs   <= 1'b0;
            morph_de   <= 1'b0;
            morph_data <= 1'b0;
        end else begin
            r_vs_d1 <= bin_vs;
            r_de_d1 <= bin_de;

            if (w_vs_rise) begin
                r_mode <= mode;
            end

            if (bin_de) begin
                if (w_inrng) begin
                    r_col <= r_col + 1'b1;
                end
            end else if (w_de_fall) begin
                r_col <= '0;
            end

            if (w_vs_rise) begin
                r_row <= '0;
            end else if (w_de_fall && r_row != '1) begin
                r_row <= r_row + 1'b1;
            end

            r_col_red  <= w_col_red;
            r_col_d1   <= r_col;
            r_inrng_d1 <= w_inrng;
            // History holds column reductions of the previous pixels on this line.
            if (bin_de) begin
                r_hist <= {r_hist[NLB-2:0], r_col_red};
            end

            morph_vs   <= r_vs_d1;
            morph_de   <= r_de_d1;
            morph_data <= r_de_d1 & r_inrng_d1 & w_win_red;
        end
    end

endmodule

// File: tb/tb_bin_morph_nxn.sv
// Scoreboard bench for bin_morph_nxn: runs 3x3 and 5x5 instances on the same
// stream and checks each output pixel against a direct window model.
module tb_bin_morph_nxn;

    localparam int W = 8;
    localparam int H = 6;

    logic video_clk = 1'b0;
    logic rst_n     = 1'b0;
    logic mode      = 1'b0;
    logic bin_vs    = 1'b0;
    logic bin_de    = 1'b0;
    logic bin_data  = 1'b0;
    logic m3_vs, m3_de, m3_data;
    logic m5_vs, m5_de, m5_data;

    always #5 video_clk = ~video_clk;

    bin_morph_nxn #(.IMG_WIDTH(W), .KSIZE(3), .CNT_W(4)) u_dut3 (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .bin_vs    (bin_vs),
        .bin_de    (bin_de),
        .bin_data  (bin_data),
        .morph_vs  (m3_vs),
        .morph_de  (m3_de),
        .morph_data(m3_data)
    );

    bin_morph_nxn #(.IMG_WIDTH(W), .KSIZE(5), .CNT_W(4)) u_dut5 (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .bin_vs    (bin_vs),
        .bin_de    (bin_de),
        .bin_data  (bin_data),
        .morph_vs  (m5_vs),
        .morph_de  (m5_de),
        .morph_data(m5_data)
    );

    int n_vec = 0;
    int n_err = 0;
    bit img [H][W];
    bit q3 [$];
    bit q5 [$];
    bit vs_h1, vs_h2, de_h1, de_h2;
    bit e3, e5;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Window covers rows r-k+1..r and cols c-k+1..c; outside the image is neutral.
    function automatic bit model(input int k, input bit dil, input int r, input int c);
        bit acc = ~dil;
        for (int dr = 0; dr < k; dr++) begin
            for (int dc = 0; dc < k; dc++) begin
                if (r - dr >= 0 && c - dc >= 0) begin
                    if (dil) acc = acc | img[r-dr][c-dc];
                    else     acc = acc & img[r-dr][c-dc];
                end
            end
        end
        return acc;
    endfunction

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic set_img(input bit fill, input int pr, input int pc);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = fill;
        if (pr >= 0) img[pr][pc] = ~fill;
    endtask

    task automatic send_frame(input int toggle_row, input int long_row, input int abort_row);
        bit eff;
        int len;
        tick();
        bin_vs = 1'b1;
        eff    = mode;
        tick();
        tick();
        bin_vs = 1'b0;
        tick();
        for (int r = 0; r < H; r++) begin
            if (r == toggle_row) mode = ~mode;
            len = (r == long_row) ? W + 2 : W;
            for (int c = 0; c < len; c++) begin
                tick();
                if (r == abort_row && c == 4) begin
                    chk("pre_rst_de3", m3_de, 1);
                    chk("pre_rst_data3", m3_data, 1);
                    bin_de   = 1'b0;
                    bin_data = 1'b0;
                    rst_n    = 1'b0;
                    #1;
                    chk("rst_vs3", m3_vs, 0);
                    chk("rst_de3", m3_de, 0);
                    chk("rst_data3", m3_data, 0);
                    chk("rst_de5", m5_de, 0);
                    chk("rst_data5", m5_data, 0);
                    return;
                end
                bin_de   = 1'b1;
                bin_data = (c < W) ? img[r][c] : 1'b1;
                q3.push_back((c < W) ? model(3, eff, r, c) : 1'b0);
                q5.push_back((c < W) ? model(5, eff, r, c) : 1'b0);
            end
            tick();
            bin_de   = 1'b0;
            bin_data = 1'b0;
            tick();
            tick();
        end
        repeat (3) tick();
    endtask

    always @(negedge video_clk) begin
        if (!rst_n) begin
            q3.delete();
            q5.delete();
            vs_h1 = 1'b0; vs_h2 = 1'b0;
            de_h1 = 1'b0; de_h2 = 1'b0;
        end else begin
            chk("vs3_delay", m3_vs, vs_h2);
            chk("de3_delay", m3_de, de_h2);
            chk("vs5_delay", m5_vs, vs_h2);
            chk("de5_delay", m5_de, de_h2);
            if (m3_de) begin
                chk("q3_nonempty", int'(q3.size() > 0), 1);
                if (q3.size() > 0) begin
                    e3 = q3.pop_front();
                    chk("data3", m3_data, e3);
                end
            end else begin
                chk("idle3", m3_data, 0);
            end
            if (m5_de) begin
                chk("q5_nonempty", int'(q5.size() > 0), 1);
                if (q5.size() > 0) begin
                    e5 = q5.pop_front();
                    chk("data5", m5_data, e5);
                end
            end else begin
                chk("idle5", m5_data, 0);
            end
            vs_h2 = vs_h1; vs_h1 = bin_vs;
            de_h2 = de_h1; de_h1 = bin_de;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("reset_vs3", m3_vs, 0);
        chk("reset_de3", m3_de, 0);
        chk("reset_data3", m3_data, 0);
        chk("reset_vs5", m5_vs, 0);
        chk("reset_de5", m5_de, 0);
        chk("reset_data5", m5_data, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        mode = 1'b0; set_img(1'b1, -1, -1); send_frame(-1, -1, -1);
        mode = 1'b1; set_img(1'b0, 2, 3);   send_frame(-1, -1, -1);
        mode = 1'b0; set_img(1'b1, 2, 3);   send_frame(-1, -1, -1);
        mode = 1'b0; set_img(1'b1, 2, 3);   send_frame(3, -1, -1);
        set_img(1'b1, -1, -1);              send_frame(-1, -1, -1);
        set_img(1'b0, 2, 3);                send_frame(2, 4, -1);
        mode = 1'b0; set_img(1'b1, 0, 0);   send_frame(-1, -1, -1);

        mode = 1'b0; set_img(1'b1, -1, -1); send_frame(-1, -1, 3);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        set_img(1'b1, 2, 3);                send_frame(-1, -1, -1);

        repeat (6) tick();
        chk("q3_drained", q3.size(), 0);
        chk("q5_drained", q5.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
